// File: rtl/mux_pkg.sv
// mux_pkg: shared state encoding for scan_mux and its pointer sub-block
package mux_pkg;
    typedef enum logic [1:0] {IDLE, SEL, SCAN} state_e;
endpackage

// File: rtl/scan_ptr.sv
// scan_ptr: dwell counter plus wrapping round-robin channel pointer
//   clk, rst  : clock, synchronous active-high reset
//   run_i     : counting enabled (mux is in SCAN)
//   clear_i   : restart at channel 0 with a fresh dwell
//   stall_i   : output slot busy; hold at end of dwell instead of advancing
//   ptr_o     : channel currently pointed at
//   tick_o    : dwell complete, ptr_o is due to be loaded
module scan_ptr #(
    parameter int N     = 4,
    parameter int DWELL = 1,
    parameter int SW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_i,
    input  logic          clear_i,
    input  logic          stall_i,
    output logic [SW-1:0] ptr_o,
    output logic          tick_o
);
    localparam int CW = $clog2(DWELL + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] ptr_q, ptr_d;
    assign tick_o = cnt_q == CW'(DWELL - 1);
    assign ptr_o  = ptr_q;
    // A stalled tick holds both counter and pointer so no channel is skipped.
    always_comb begin
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        if (clear_i) begin
            cnt_d = '0;
            ptr_d = '0;
        end else if (run_i && !tick_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (run_i && !stall_i) begin
            cnt_d = '0;
            ptr_d = (ptr_q == SW'(N - 1)) ? '0 : ptr_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/scan_mux.sv
// scan_mux: N-channel W-bit registered mux, direct select or dwell-timed round-robin scan
//   clk, rst : clock, synchronous active-high reset
//   en, mode : 0 -> IDLE; mode 0 -> direct select, mode 1 -> auto-scan
//   s        : direct-mode channel select
//   I        : packed channels, channel k at I[k*W +: W]
//   y, y_ch  : registered sample and its channel index
//   y_valid  : sample pending; y_ready accepts it
//   err      : one-cycle pulse for an out-of-range direct select
module scan_mux import mux_pkg::*; #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SW    = $clog2(N),
    parameter int DWELL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] I,
    output logic [W-1:0]   y,
    output logic [SW-1:0]  y_ch,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           err
);
    state_e        state_q, state_d;
    logic [W-1:0]  y_q;
    logic [SW-1:0] y_ch_q, ch, ptr;
    logic          y_valid_q, err_q, free, bad, load, tick;
    assign state_d = !en ? IDLE : (mode ? SCAN : SEL);
    assign free    = !y_valid_q || y_ready;
    assign bad     = state_q == SEL && int'(s) >= N;
    assign ch      = (state_q == SCAN) ? ptr : s;
    assign load    = free && ((state_q == SEL && !bad) || (state_q == SCAN && tick));
    // Pointer restarts only on the transition into SCAN, never while staying there.
    scan_ptr #(.N(N), .DWELL(DWELL), .SW(SW)) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .run_i  (state_q == SCAN),
        .clear_i(state_d == SCAN && state_q != SCAN),
        .stall_i(!free),
        .ptr_o  (ptr),
        .tick_o (tick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= bad;
            if (load) begin
                y_q       <= I[ch*W +: W];
                y_ch_q    <= ch;
                y_valid_q <= 1'b1;
            end else if (free) begin
                y_valid_q <= 1'b0;
            end
        end
    end
    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign err     = err_q;
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: table vectors, corner sequences and random stimulus against a behavioural model
module tb_scan_mux;
    logic        clk = 1'b0;
    logic        rst, en, mode, y_ready;
    logic [2:0]  s;
    logic [39:0] I;
    logic [7:0]  y_a, y_b;
    logic [1:0]  ych_a;
    logic [2:0]  ych_b;
    logic        yv_a, yv_b, err_a, err_b;
    int vectors = 0, miscompares = 0;
    int st[2], pos[2], el[2], mch[2];
    logic [7:0] my[2];
    bit mv[2], me[2];

    always #5 clk = ~clk;

    scan_mux #(.N(4), .W(8), .DWELL(3)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s[1:0]), .I(I[31:0]),
        .y(y_a), .y_ch(ych_a), .y_valid(yv_a), .y_ready(y_ready), .err(err_a)
    );
    scan_mux #(.N(5), .W(8), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .I(I),
        .y(y_b), .y_ch(ych_b), .y_valid(yv_b), .y_ready(y_ready), .err(err_b)
    );

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 direct, 2 scan; el = cycles already spent dwelling on pos.
    task automatic model_step(int k, bit r, bit e, bit m, int ss, bit rdy, logic [39:0] ii);
        int n = (k == 0) ? 4 : 5;
        int dw = (k == 0) ? 3 : 1;
        int sv = (k == 0) ? ss % 4 : ss;
        int nst;
        bit free;
        if (r) begin
            st[k] = 0; pos[k] = 0; el[k] = 0; my[k] = 0; mch[k] = 0; mv[k] = 0; me[k] = 0;
            return;
        end
        free = !mv[k] || rdy;
        me[k] = st[k] == 1 && sv >= n;
        if (st[k] == 1 && sv < n && free) begin
            my[k] = ii[sv*8 +: 8]; mch[k] = sv; mv[k] = 1;
        end else if (st[k] == 2 && el[k] == dw - 1) begin
            if (free) begin
                my[k] = ii[pos[k]*8 +: 8]; mch[k] = pos[k]; mv[k] = 1;
                pos[k] = (pos[k] + 1) % n;
                el[k] = 0;
            end
        end else begin
            if (st[k] == 2) el[k]++;
            if (free) mv[k] = 0;
        end
        nst = !e ? 0 : (m ? 2 : 1);
        if (nst == 2 && st[k] != 2) begin
            pos[k] = 0; el[k] = 0;
        end
        st[k] = nst;
    endtask

    task automatic cyc(bit r, bit e, bit m, int ss, bit rdy);
        rst = r; en = e; mode = m; s = 3'(ss); y_ready = rdy;
        @(posedge clk);
        model_step(0, r, e, m, ss, rdy, I);
        model_step(1, r, e, m, ss, rdy, I);
        #1;
        chk("model_a", {y_a, 8'(ych_a), 8'(yv_a), 8'(err_a)}, {my[0], 8'(mch[0]), 8'(mv[0]), 8'(me[0])});
        chk("model_b", {y_b, 8'(ych_b), 8'(yv_b), 8'(err_b)}, {my[1], 8'(mch[1]), 8'(mv[1]), 8'(me[1])});
    endtask

    typedef struct {
        bit r, e, m;
        int s;
        bit rdy;
        logic [7:0] y;
        logic [1:0] ch;
        bit v, err;
    } vec_t;
    vec_t tbl[$];

    initial begin
        bit re, rm;
        logic [7:0] py;
        logic [1:0] pc;
        I = 40'h55_44_33_22_11;
        tbl.push_back('{1, 0, 0, 0, 1, 8'h00, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 8'h00, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 1, 8'h11, 2'd0, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 8'h22, 2'd1, 1, 0});
        tbl.push_back('{0, 1, 0, 2, 1, 8'h33, 2'd2, 1, 0});
        tbl.push_back('{0, 1, 0, 3, 1, 8'h44, 2'd3, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 8'h11, 2'd0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 8'h11, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 8'h11, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 8'h11, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 8'h11, 2'd0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 1, 8'h11, 2'd0, 1, 0});
        py = 8'h11; pc = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back('{0, 1, 1, 0, 1, py, pc, 0, 0});
            tbl.push_back('{0, 1, 1, 0, 1, py, pc, 0, 0});
            pc = 2'(k % 4);
            py = 8'h11 * (8'(pc) + 8'd1);
            tbl.push_back('{0, 1, 1, 0, 1, py, pc, 1, 0});
        end
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].rdy);
            chk("tbl_a", {y_a, 8'(ych_a), 8'(yv_a), 8'(err_a)},
                {tbl[i].y, 8'(tbl[i].ch), 8'(tbl[i].v), 8'(tbl[i].err)});
        end

        // Stall at channel 2 (DWELL=1): hold, then resume at 3.
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        chk("scan_first_ch", 32'(ych_b), 0);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        chk("scan_ch2", {y_b, 8'(ych_b), 8'(yv_b)}, {8'h33, 8'd2, 8'd1});
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("stall_hold", {y_b, 8'(ych_b), 8'(yv_b)}, {8'h33, 8'd2, 8'd1});
        end
        cyc(0, 1, 1, 0, 1);
        chk("stall_noskip", {y_b, 8'(ych_b), 8'(yv_b)}, {8'h44, 8'd3, 8'd1});

        // Out-of-range select on N=5.
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        chk("sel_load", {y_b, 8'(ych_b), 8'(yv_b), 8'(err_b)}, {8'h22, 8'd1, 8'd1, 8'd0});
        cyc(0, 1, 0, 6, 1);
        chk("err_pulse", {y_b, 8'(ych_b), 8'(yv_b), 8'(err_b)}, {8'h22, 8'd1, 8'd0, 8'd1});
        cyc(0, 1, 0, 4, 1);
        chk("err_clear", {y_b, 8'(ych_b), 8'(yv_b), 8'(err_b)}, {8'h55, 8'd4, 8'd1, 8'd0});

        // Reset mid-scan at ptr=2, then restart from channel 0.
        cyc(1, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(1, 1, 1, 0, 1);
        chk("rst_mid", {y_b, 8'(ych_b), 8'(yv_b), 8'(err_b)}, 32'd0);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        chk("rst_restart", {y_b, 8'(ych_b), 8'(yv_b)}, {8'h11, 8'd0, 8'd1});

        // SCAN -> SEL -> SCAN re-entry restarts at channel 0.
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 0, 1, 1);
        chk("leave_scan", 32'(ych_b), 3);
        cyc(0, 1, 1, 1, 1);
        chk("sel_between", 32'(ych_b), 1);
        cyc(0, 1, 1, 0, 1);
        chk("reentry_ch0", {y_b, 8'(ych_b)}, {8'h11, 8'd0});

        // Random traffic, mode/enable held for stretches so dwell and stalls interact.
        re = 1; rm = 1;
        for (int i = 0; i < 800; i++) begin
            I = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 19) == 0) rm = ~rm;
            if ($urandom_range(0, 29) == 0) re = ~re;
            cyc($urandom_range(0, 99) == 0, re, rm, int'($urandom_range(0, 7)),
                $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit registered multiplexer with a ready/valid output, in two modes. In direct mode an external select picks the channel each cycle. In scan mode an internal pointer visits channels round-robin, holding each for a programmable dwell time. It is the multi-bit, multi-channel, clocked successor of the team's 4:1 single-bit select mux. It feeds sampled channel data to downstream logic that may stall.

## Interface
Parameters:
- N, 4, number of input channels (N ≥ 2, need not be a power of two)
- W, 1, bits per channel
- SW, $clog2(N), select/pointer width (derived; do not override)
- DWELL, 1, cycles per channel in scan mode (DWELL ≥ 1)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; 0 forces IDLE
- mode  in  1  0 = direct select, 1 = auto-scan
- s  in  SW  channel select, used in direct mode only
- I  in  N*W  packed channels; channel k is I[k*W +: W]
- y  out  W  registered selected data
- y_ch  out  SW  channel index that produced y
- y_valid  out  1  y/y_ch hold a sample not yet accepted
- y_ready  in  1  downstream accepts when y_valid && y_ready
- err  out  1  one-cycle pulse: out-of-range select in direct mode

## Operation
- State register, next-state rule evaluated every cycle: IDLE if !en; SEL if en && !mode; SCAN if en && mode. Actions in a cycle depend on the current (registered) state.
- Output slot is free when !y_valid || y_ready. A load is allowed only when the slot is free.
- A load captures I[ch] into y and ch into y_ch, and sets y_valid=1.
- If the slot is free and no load occurs, y_valid clears. y and y_ch keep their last values.
- IDLE: no loads; ptr and cnt hold; y_valid drains normally on acceptance.
- SEL: on each free-slot cycle, load channel s.
  - If s ≥ N: no load, err=1 for that cycle, y_valid clears if accepted.
- SCAN: cnt counts 0..DWELL-1.
  - At cnt==DWELL-1 with a free slot: load channel ptr, cnt←0, ptr←(ptr==N-1)?0:ptr+1.
  - At cnt==DWELL-1 with the slot stalled: cnt and ptr hold. No channel is skipped or duplicated.
  - Below DWELL-1: cnt increments regardless of stall.
- Entering SCAN from any other state: ptr←0 and cnt←0 in that transition cycle.
- Leaving SCAN keeps ptr and cnt, but re-entry resets them as above.
- Data is sampled from I in the load cycle. Later changes to I do not affect a held y.

## Timing
- Reset values: y=0, y_ch=0, y_valid=0, err=0, state=IDLE, ptr=0, cnt=0.
- Reset mid-operation discards any pending sample.
- Latency: en/mode sampled at edge t → state valid after t → first SEL load at edge t+1, so y_valid is high after t+1.
- First SCAN load occurs DWELL edges after entry.
- Throughput:
  - SEL: one sample per cycle with y_ready held high.
  - SCAN: one sample per DWELL cycles.
- err is combinational-free (registered) and asserted in the cycle after the offending select is sampled, alongside the suppressed load.
- Simultaneous accept and load: the new sample replaces the old one in the same edge, and y_valid stays 1.

## Structure
- Package mux_pkg: state typedef (IDLE, SEL, SCAN) and a clog2 constant function if the toolchain lacks $clog2.
- One sub-module, scan_ptr: dwell counter plus wrapping pointer. Inputs: clear, stall. Outputs: ptr, tick. Instantiated once.
- Remaining logic (FSM, output register, range check) stays in scan_mux.

## Test plan
- N=4, W=8, I={8'h44,8'h33,8'h22,8'h11}, SEL, y_ready=1, s=0,1,2,3 on consecutive cycles → y=11,22,33,44 with y_ch=0..3, one cycle after each s.
- SCAN, DWELL=3, y_ready=1 → loads every 3rd cycle with y_ch sequence 0,1,2,3,0,1; first load 3 edges after entry.
- SCAN, DWELL=1, y_ready low for 4 cycles while y_ch=2 → y and y_ch hold at 2, y_valid=1; after release, next y_ch=3 (no skip).
- N=5, SEL, s=6 → err pulses 1 cycle, no load, y_valid=0 after acceptance; then s=4 → y=channel 4, err=0.
- Reset asserted mid-scan at ptr=2 → next cycle y=0, y_valid=0, ptr=0; re-enable SCAN → restarts at channel 0.
- SCAN→SEL→SCAN toggle with ptr=3 → on re-entry the first loaded channel is 0.
